// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU control, funct codes,
// control-vector bit positions and the multiplier state type.
package cpu_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ORI   = 2'b11;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;

    // Positions inside the [0:8] control vector
    localparam int CB_ALUSRC = 1;
    localparam int CB_BRANCH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mult_unit.sv
// Iterative 32-step shift-add multiplier with HI/LO result registers.
// Signed operation multiplies magnitudes and negates the 64-bit product
// at the end when the operand signs differ.
module mult_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mult_state_e state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] partial_s;
    logic [63:0] acc_step_s;
    logic [63:0] product_s;

    // Next-state, datapath step and busy (stall) generation
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        neg_d      = neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy       = 1'b0;
        partial_s  = b_q[count_q] ? ({32'd0, a_q} << count_q) : 64'd0;
        acc_step_s = acc_q + partial_s;
        product_s  = neg_q ? (64'd0 - acc_step_s) : acc_step_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy    = 1'b1;
                    a_d     = signed_op ? abs32(a) : a;
                    b_d     = signed_op ? abs32(b) : b;
                    neg_d   = signed_op & (a[31] ^ b[31]);
                    acc_d   = 64'd0;
                    count_d = 5'd0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                busy    = 1'b1;
                acc_d   = acc_step_s;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    hi_d    = product_s[63:32];
                    lo_d    = product_s[31:0];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                // The held multiply leaves EX now; a start seen here is ignored
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand, accumulator and HI/LO registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= 5'd0;
            acc_q   <= 64'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            neg_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, pass-throughs, and the multiplier
// stall that freezes the front of the pipeline and bubbles EX/MEM.
module ex_stage
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inR1,
    input  logic [31:0] inR2,
    input  logic [31:0] inAddress,
    input  logic [1:0]  inAluCtrl,
    input  logic [0:8]  inControlBits,
    input  logic [4:0]  inWriteRegister,
    input  logic [31:0] inPc,
    output logic [31:0] outAluResult,
    output logic        outZero,
    output logic [31:0] outBranchTarget,
    output logic [31:0] outR2,
    output logic [0:8]  outControlBits,
    output logic [4:0]  outWriteRegister,
    output logic        stall
);

    logic [5:0]  funct_s;
    logic [31:0] opb_s;
    logic [31:0] alu_res_s;
    logic        mul_start_s;
    logic        mul_signed_s;
    logic        mul_busy_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;

    assign funct_s = inAddress[5:0];

    // Operand B select and ALU / HI / LO result mux
    always_comb begin
        opb_s     = inControlBits[CB_ALUSRC] ? inAddress : inR2;
        alu_res_s = 32'd0;
        case (inAluCtrl)
            ALU_ADD: alu_res_s = inR1 + opb_s;
            ALU_SUB: alu_res_s = inR1 - opb_s;
            ALU_ORI: alu_res_s = inR1 | {16'd0, inAddress[15:0]};
            ALU_RTYPE: begin
                case (funct_s)
                    FN_ADD, FN_ADDU: alu_res_s = inR1 + opb_s;
                    FN_SUB, FN_SUBU: alu_res_s = inR1 - opb_s;
                    FN_AND:  alu_res_s = inR1 & opb_s;
                    FN_OR:   alu_res_s = inR1 | opb_s;
                    FN_XOR:  alu_res_s = inR1 ^ opb_s;
                    FN_NOR:  alu_res_s = ~(inR1 | opb_s);
                    FN_SLT:  alu_res_s = ($signed(inR1) < $signed(opb_s)) ? 32'd1 : 32'd0;
                    FN_SLTU: alu_res_s = (inR1 < opb_s) ? 32'd1 : 32'd0;
                    FN_MFHI: alu_res_s = hi_s;
                    FN_MFLO: alu_res_s = lo_s;
                    default: alu_res_s = 32'd0;
                endcase
            end
            default: alu_res_s = 32'd0;
        endcase
    end

    // Multiply start decode; MULT and MULTU only, both yield ALU result 0
    always_comb begin
        mul_start_s  = 1'b0;
        mul_signed_s = 1'b0;
        if (inAluCtrl == ALU_RTYPE) begin
            if (funct_s == FN_MULT) begin
                mul_start_s  = 1'b1;
                mul_signed_s = 1'b1;
            end else if (funct_s == FN_MULTU) begin
                mul_start_s  = 1'b1;
            end else begin
                mul_start_s  = 1'b0;
            end
        end else begin
            mul_start_s = 1'b0;
        end
    end

    mult_unit u_mult (
        .clock     (clock),
        .reset     (reset),
        .start     (mul_start_s),
        .signed_op (mul_signed_s),
        .a         (inR1),
        .b         (inR2),
        .busy      (mul_busy_s),
        .hi        (hi_s),
        .lo        (lo_s)
    );

    // Stage outputs; control is squashed to a bubble while stalling
    always_comb begin
        outAluResult     = alu_res_s;
        outZero          = (alu_res_s == 32'd0);
        outBranchTarget  = inPc + {inAddress[29:0], 2'b00};
        outR2            = inR2;
        outWriteRegister = inWriteRegister;
        stall            = mul_busy_s;
        if (mul_busy_s) begin
            outControlBits = 9'd0;
        end else begin
            outControlBits = inControlBits;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a scoreboard queue receives the expected
// outputs as each input vector is driven and is drained on the falling edge.
module tb_ex_stage;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inR1, inR2, inAddress, inPc;
    logic [1:0]  inAluCtrl;
    logic [0:8]  inControlBits;
    logic [4:0]  inWriteRegister;
    logic [31:0] outAluResult, outBranchTarget, outR2;
    logic        outZero, stall;
    logic [0:8]  outControlBits;
    logic [4:0]  outWriteRegister;

    ex_stage dut (
        .clock            (clock),
        .reset            (reset),
        .inR1             (inR1),
        .inR2             (inR2),
        .inAddress        (inAddress),
        .inAluCtrl        (inAluCtrl),
        .inControlBits    (inControlBits),
        .inWriteRegister  (inWriteRegister),
        .inPc             (inPc),
        .outAluResult     (outAluResult),
        .outZero          (outZero),
        .outBranchTarget  (outBranchTarget),
        .outR2            (outR2),
        .outControlBits   (outControlBits),
        .outWriteRegister (outWriteRegister),
        .stall            (stall)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [31:0] tgt;
        logic [31:0] r2;
        logic [4:0]  wr;
        logic [0:8]  ctrl;
        logic        stall;
        logic        chk;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    localparam logic [0:8] CB_NONE = 9'b000000000;
    localparam logic [0:8] CB_RT   = 9'b100000011;
    localparam logic [0:8] CB_IMM  = 9'b110000001;
    localparam logic [0:8] CB_BEQ  = 9'b001000000;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Pop one expectation and compare it with the current DUT outputs
    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, ".stall"}, {63'd0, stall}, {63'd0, e.stall});
            check_val({tag, ".ctrl"}, {55'd0, outControlBits}, {55'd0, e.ctrl});
            if (e.chk) begin
                check_val({tag, ".res"}, {32'd0, outAluResult}, {32'd0, e.res});
                check_val({tag, ".zero"}, {63'd0, outZero}, {63'd0, e.zero});
                check_val({tag, ".tgt"}, {32'd0, outBranchTarget}, {32'd0, e.tgt});
                check_val({tag, ".r2"}, {32'd0, outR2}, {32'd0, e.r2});
                check_val({tag, ".wr"}, {59'd0, outWriteRegister}, {59'd0, e.wr});
            end
        end
    endtask

    // Drive one cycle of inputs, push the expectation, check on the falling edge
    task automatic drive(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] addr, input logic [1:0] ac, input logic [0:8] cb,
                         input logic [31:0] pc, input logic exp_stall, input logic [31:0] exp_res);
        exp_t e;
        logic [4:0] wr;
        @(posedge clock);
        #1;
        reset           = 1'b0;
        wr              = 5'($urandom_range(0, 31));
        inR1            = r1;
        inR2            = r2;
        inAddress       = addr;
        inAluCtrl       = ac;
        inControlBits   = cb;
        inWriteRegister = wr;
        inPc            = pc;
        e.res   = exp_res;
        e.zero  = (exp_res == 32'd0);
        e.tgt   = pc + (addr << 2);
        e.r2    = r2;
        e.wr    = wr;
        e.ctrl  = exp_stall ? 9'd0 : cb;
        e.stall = exp_stall;
        e.chk   = !exp_stall;
        exp_q.push_back(e);
        @(negedge clock);
        compare(tag);
    endtask

    // Full multiply: 33 stalled cycles, DONE cycle, then MFLO and MFHI readback
    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] fn;
        logic [63:0] xa, xb, p;
        fn = sgn ? {26'd0, FN_MULT} : {26'd0, FN_MULTU};
        for (int i = 0; i < 33; i++)
            drive({tag, ".busy"}, a, b, fn, ALU_RTYPE, CB_RT, 32'h200, 1'b1, 32'd0);
        drive({tag, ".done"}, a, b, fn, ALU_RTYPE, CB_RT, 32'h200, 1'b0, 32'd0);
        xa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        m_hi = p[63:32];
        m_lo = p[31:0];
        drive({tag, ".mflo"}, 32'd0, 32'd0, {26'd0, FN_MFLO}, ALU_RTYPE, CB_RT, 32'h204, 1'b0, m_lo);
        drive({tag, ".mfhi"}, 32'd0, 32'd0, {26'd0, FN_MFHI}, ALU_RTYPE, CB_RT, 32'h208, 1'b0, m_hi);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inR1 = 32'd0; inR2 = 32'd0; inAddress = 32'd0; inAluCtrl = ALU_ADD;
        inControlBits = CB_NONE; inWriteRegister = 5'd0; inPc = 32'd0;
        repeat (3) @(posedge clock);

        // Post-reset state: no stall, HI/LO cleared
        drive("rst.nop",  32'd0, 32'd0, 32'd0, ALU_ADD, CB_NONE, 32'd0, 1'b0, 32'd0);
        drive("rst.mfhi", 32'd0, 32'd0, {26'd0, FN_MFHI}, ALU_RTYPE, CB_RT, 32'd4, 1'b0, 32'd0);
        drive("rst.mflo", 32'd0, 32'd0, {26'd0, FN_MFLO}, ALU_RTYPE, CB_RT, 32'd8, 1'b0, 32'd0);

        // Combinational ALU vectors with hand-computed results
        drive("add_ovf", 32'h7FFFFFFF, 32'h1, {26'd0, FN_ADD}, ALU_RTYPE, CB_RT, 32'h10, 1'b0, 32'h80000000);
        drive("slt",     32'hFFFFFFFF, 32'h1, {26'd0, FN_SLT}, ALU_RTYPE, CB_RT, 32'h14, 1'b0, 32'h1);
        drive("sltu",    32'hFFFFFFFF, 32'h1, {26'd0, FN_SLTU}, ALU_RTYPE, CB_RT, 32'h18, 1'b0, 32'h0);
        drive("beq",     32'h5, 32'h5, 32'hFFFFFFFE, ALU_SUB, CB_BEQ, 32'h100, 1'b0, 32'h0);
        drive("sub",     32'h3, 32'h5, {26'd0, FN_SUB}, ALU_RTYPE, CB_RT, 32'h20, 1'b0, 32'hFFFFFFFE);
        drive("subu",    32'h0, 32'h1, {26'd0, FN_SUBU}, ALU_RTYPE, CB_RT, 32'h24, 1'b0, 32'hFFFFFFFF);
        drive("addu",    32'hFFFFFFFF, 32'h2, {26'd0, FN_ADDU}, ALU_RTYPE, CB_RT, 32'h28, 1'b0, 32'h1);
        drive("and",     32'hF0F0FFFF, 32'h0FF00F0F, {26'd0, FN_AND}, ALU_RTYPE, CB_RT, 32'h2C, 1'b0, 32'h00F00F0F);
        drive("or",      32'hF0F0FFFF, 32'h0FF00F0F, {26'd0, FN_OR}, ALU_RTYPE, CB_RT, 32'h30, 1'b0, 32'hFFF0FFFF);
        drive("xor",     32'hF0F0FFFF, 32'h0FF00F0F, {26'd0, FN_XOR}, ALU_RTYPE, CB_RT, 32'h34, 1'b0, 32'hFF00F0F0);
        drive("nor",     32'hF0F0FFFF, 32'h0FF00F0F, {26'd0, FN_NOR}, ALU_RTYPE, CB_RT, 32'h38, 1'b0, 32'h000F0000);
        drive("ori",     32'h12340000, 32'h0, 32'hFFFF8001, ALU_ORI, CB_IMM, 32'h3C, 1'b0, 32'h12348001);
        drive("addi",    32'd10, 32'h55, 32'hFFFFFFFF, ALU_ADD, CB_IMM, 32'h40, 1'b0, 32'd9);
        drive("bad_fn",  32'h1234, 32'h5678, 32'h0000003F, ALU_RTYPE, CB_RT, 32'h44, 1'b0, 32'h0);

        // Multiplies: signed negative product, then unsigned large operand
        run_mult("mult_m5x7", 32'hFFFFFFFB, 32'd7, 1'b1);
        run_mult("multu",     32'hFFFFFFFF, 32'd2, 1'b0);

        // Reset during BUSY at count=10 discards the multiply and clears HI/LO
        for (int i = 0; i < 12; i++)
            drive("rstmul.busy", 32'd3, 32'd4, {26'd0, FN_MULT}, ALU_RTYPE, CB_RT, 32'h300, 1'b1, 32'd0);
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        drive("rstmul.mfhi", 32'd0, 32'd0, {26'd0, FN_MFHI}, ALU_RTYPE, CB_RT, 32'h304, 1'b0, 32'd0);
        drive("rstmul.mflo", 32'd0, 32'd0, {26'd0, FN_MFLO}, ALU_RTYPE, CB_RT, 32'h308, 1'b0, 32'd0);
        run_mult("mult_after_rst", 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b1);
        run_mult("mult_rand", $urandom, $urandom, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
